// File: rtl/mig_tt_sequencer_if.sv
// rtl/mig_tt_sequencer_if.sv - host-side bus of the majority-network truth-table evaluator
//
// Groups the gate-store write port, the run-control inputs and the status/result outputs.
//   master : host side (drives cfg_* / start / num_gates / out_sel / out_inv)
//   slave  : evaluator side (drives busy / done / err / tt)
interface mig_tt_sequencer_if #(
  parameter int MAX_GATES = 8,
  parameter int IDXW      = 4
);
  localparam int AW = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1;
  localparam int NW = $clog2(MAX_GATES + 1);
  localparam int DW = 3 * (IDXW + 1);

  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [DW-1:0]   cfg_data;
  logic            start;
  logic [NW-1:0]   num_gates;
  logic [IDXW-1:0] out_sel;
  logic            out_inv;
  logic            busy;
  logic            done;
  logic            err;
  logic [15:0]     tt;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, num_gates, out_sel, out_inv,
    input  busy, done, err, tt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, num_gates, out_sel, out_inv,
    output busy, done, err, tt
  );
endinterface

// File: rtl/mig_tt_sequencer.sv
// rtl/mig_tt_sequencer.sv - one-gate-per-cycle evaluator for 4-input majority-inverter networks
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mig_tt_sequencer_if.slave (gate-store writes, start/num_gates/out_sel/out_inv,
//          busy/done/err/tt)
// Node map: 0 = const 0, 1..4 = x0..x3, 5+g = output of gate g.
module mig_tt_sequencer #(
  parameter int MAX_GATES = 8,
  parameter int IDXW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mig_tt_sequencer_if.slave    bus
);
  localparam int AW = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1;
  localparam int NW = $clog2(MAX_GATES + 1);
  localparam int DW = 3 * (IDXW + 1);
  localparam int NN = 1 << IDXW;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   g_q, g_d;
  logic [NW-1:0]   n_q, n_d;
  logic [IDXW-1:0] sel_q, sel_d;
  logic            inv_q, inv_d;
  logic            err_q, err_d;
  logic [15:0]     tt_q, tt_d;
  logic [DW-1:0]   gate_q [MAX_GATES];
  logic [DW-1:0]   gate_d [MAX_GATES];
  logic [15:0]     node_q [MAX_GATES];
  logic [15:0]     node_d [MAX_GATES];

  logic [15:0]     nv [NN];
  logic [DW-1:0]   cur;
  logic [IDXW-1:0] op_idx [3];
  logic [15:0]     op_val [3];
  logic [15:0]     maj;
  logic [15:0]     res;
  logic            topo_ok;
  logic            start_ok;
  logic            last_gate;

  // Flat view of every addressable node; unused indices read as zero.
  always_comb begin
    for (int i = 0; i < NN; i++) nv[i] = '0;
    nv[1] = 16'hAAAA;
    nv[2] = 16'hCCCC;
    nv[3] = 16'hF0F0;
    nv[4] = 16'hFF00;
    for (int g = 0; g < MAX_GATES; g++) nv[5+g] = node_q[g];
  end

  // Current gate: operand fetch, topological check and bitwise majority.
  always_comb begin
    cur     = gate_q[g_q];
    topo_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      op_idx[k] = cur[k*(IDXW+1) +: IDXW];
      op_val[k] = nv[op_idx[k]] ^ {16{cur[k*(IDXW+1)+IDXW]}};
      if (int'(op_idx[k]) > int'(g_q) + 4) topo_ok = 1'b0;
    end
    maj = (op_val[0] & op_val[1]) | (op_val[0] & op_val[2]) | (op_val[1] & op_val[2]);
    // The selected output may be the gate being computed this very cycle,
    // whose node register is not written yet: bypass it.
    if (int'(sel_q) == int'(g_q) + 5) res = maj;
    else                              res = nv[sel_q];
  end

  assign start_ok  = (int'(bus.num_gates) >= 1) && (int'(bus.num_gates) <= MAX_GATES) &&
                     (int'(bus.out_sel) <= 4 + int'(bus.num_gates));
  assign last_gate = (int'(g_q) == int'(n_q) - 1);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    n_d     = n_q;
    sel_d   = sel_q;
    inv_d   = inv_q;
    err_d   = err_q;
    tt_d    = tt_q;
    gate_d  = gate_q;
    node_d  = node_q;

    // Program is frozen while evaluating; a write alongside an accepted start
    // lands before gate 0 is fetched in the next cycle.
    if (bus.cfg_we && state_q != S_EVAL && int'(bus.cfg_addr) < MAX_GATES)
      gate_d[bus.cfg_addr] = bus.cfg_data;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d   = bus.num_gates;
          sel_d = bus.out_sel;
          inv_d = bus.out_inv;
          g_d   = '0;
          tt_d  = '0;
          if (start_ok) begin
            err_d   = 1'b0;
            state_d = S_EVAL;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_EVAL: begin
        if (!topo_ok) begin
          err_d   = 1'b1;
          tt_d    = '0;
          state_d = S_DONE;
        end else begin
          node_d[g_q] = maj;
          if (last_gate) begin
            err_d   = 1'b0;
            tt_d    = res ^ {16{inv_q}};
            state_d = S_DONE;
          end else begin
            g_d = g_q + AW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      n_q     <= '0;
      sel_q   <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
      tt_q    <= '0;
      for (int i = 0; i < MAX_GATES; i++) gate_q[i] <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      n_q     <= n_d;
      sel_q   <= sel_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
      tt_q    <= tt_d;
      gate_q  <= gate_d;
    end
  end

  // Node values are never cleared; the topological check keeps stale ones unread.
  always_ff @(posedge clk) begin
    node_q <= node_d;
  end

  assign bus.busy = (state_q == S_EVAL);
  assign bus.done = (state_q == S_DONE);
  assign bus.err  = err_q;
  assign bus.tt   = tt_q;
endmodule
